// File: rtl/drive_seq_pkg.sv
// Shared types and field layout for the drive sequence scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package drive_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DWELL = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Config address that selects the control register instead of a step entry
  localparam logic [4:0] CTRL_ADDR = 5'd16;

  // Step entry layout: dwell occupies the low bits, the driver mask sits directly above it
  localparam int STEP_DWELL_LSB = 0;

  // Control register layout
  localparam int CTRL_LAST_STEP_LSB = 0;
  localparam int CTRL_LAST_STEP_W   = 4;
  localparam int CTRL_LOOP_LSB      = 8;
  localparam int CTRL_LOOP_W        = 8;

  function automatic int step_mask_lsb(input int dwell_w);
    return STEP_DWELL_LSB + dwell_w;
  endfunction

  function automatic int step_entry_w(input int num_drivers, input int dwell_w);
    return num_drivers + dwell_w;
  endfunction

endpackage

// File: rtl/drive_seq_step_table.sv
// Step table: NUM_STEPS entries of {mask, dwell}, one write port, one combinational read port.
// Latency: write visible on the cycle after the strobe; read is combinational.
// Backpressure: none; the write strobe is always accepted.
module drive_seq_step_table #(
  parameter int NUM_STEPS = 16,
  parameter int ENTRY_W   = 24
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_wr_en,
  input  logic [3:0]         i_wr_addr,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic [3:0]         i_rd_addr,
  output logic [ENTRY_W-1:0] o_rd_data
);

  logic [ENTRY_W-1:0] r_mem [NUM_STEPS];

  // Entry storage, wiped on reset so an unprogrammed table drives nothing
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/drive_sequence_scheduler.sv
// Steps a programmed table of driver masks, handshaking each step with the backend then dwelling; DRIVE_SEQ_LOOP_EN adds repeat passes.
// Latency: start to timer_enable high is 2 cycles; each step costs wait + (dwell+1) + 2 cycles.
// Backpressure: WAIT holds timer_enable until update_cycle_complete; config writes while busy are dropped and flagged.
module drive_sequence_scheduler
  import drive_seq_pkg::*;
#(
  parameter int NUM_OF_DRIVERS = 8,
  parameter int NUM_STEPS      = 16,
  parameter int DWELL_W        = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_write_n,
  input  logic [4:0]                cfg_address,
  input  logic [31:0]               cfg_data,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      update_cycle_complete,
  output logic                      timer_enable,
  output logic [NUM_OF_DRIVERS-1:0] driver_enable,
  output logic                      busy,
  output logic [3:0]                step_index,
  output logic                      done,
  output logic                      cfg_busy_error
);

  localparam int ENTRY_W  = step_entry_w(NUM_OF_DRIVERS, DWELL_W);
  localparam int MASK_LSB = step_mask_lsb(DWELL_W);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [3:0]                r_step_index;
  logic [3:0]                r_last_step;
  logic [DWELL_W-1:0]        r_dwell_cnt;
  logic [NUM_OF_DRIVERS-1:0] r_driver_enable;
  logic                      r_timer_enable;
  logic                      r_cfg_busy_error;

  logic                      w_cfg_wr;
  logic                      w_cfg_wr_ok;
  logic                      w_tbl_we;
  logic                      w_ctrl_we;
  logic [3:0]                w_last_step_wr;
  logic [ENTRY_W-1:0]        w_tbl_rd;
  logic [NUM_OF_DRIVERS-1:0] w_rd_mask;
  logic [DWELL_W-1:0]        w_rd_dwell;
  logic                      w_at_last;
  logic                      w_loop_again;
  logic                      w_unused;

  // Config writes only land while idle; anything else is dropped and flagged
  assign w_cfg_wr    = !cfg_write_n;
  assign w_cfg_wr_ok = w_cfg_wr && (r_state == ST_IDLE);
  assign w_tbl_we    = w_cfg_wr_ok && (cfg_address < 5'(NUM_STEPS));
  assign w_ctrl_we   = w_cfg_wr_ok && (cfg_address == CTRL_ADDR);
  assign w_unused    = ^cfg_data[31:ENTRY_W];

  // Clamp an out-of-range last_step so the walk never leaves the table
  always_comb begin
    w_last_step_wr = cfg_data[CTRL_LAST_STEP_LSB +: CTRL_LAST_STEP_W];
    if ({1'b0, w_last_step_wr} >= 5'(NUM_STEPS)) begin
      w_last_step_wr = 4'(NUM_STEPS - 1);
    end
  end

  drive_seq_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .ENTRY_W   (ENTRY_W)
  ) u_step_table (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_wr_en   (w_tbl_we),
    .i_wr_addr (cfg_address[3:0]),
    .i_wr_data (cfg_data[ENTRY_W-1:0]),
    .i_rd_addr (r_step_index),
    .o_rd_data (w_tbl_rd)
  );

  assign w_rd_mask  = w_tbl_rd[MASK_LSB +: NUM_OF_DRIVERS];
  assign w_rd_dwell = w_tbl_rd[STEP_DWELL_LSB +: DWELL_W];
  assign w_at_last  = (r_step_index == r_last_step);

`ifdef DRIVE_SEQ_LOOP_EN
  logic [CTRL_LOOP_W-1:0] r_loop_count;
  logic [CTRL_LOOP_W-1:0] r_loops_left;

  // Repeat-pass bookkeeping: latch the count at start, spend one per wrap to step 0
  always_ff @(posedge clock) begin
    if (reset) begin
      r_loop_count <= '0;
      r_loops_left <= '0;
    end else begin
      if (w_ctrl_we) begin
        r_loop_count <= cfg_data[CTRL_LOOP_LSB +: CTRL_LOOP_W];
      end
      if (r_state == ST_IDLE && start && !abort) begin
        r_loops_left <= r_loop_count;
      end else if (r_state == ST_NEXT && w_at_last && w_loop_again) begin
        r_loops_left <= r_loops_left - CTRL_LOOP_W'(1);
      end
    end
  end

  assign w_loop_again = (r_loops_left != '0);
`else
  assign w_loop_again = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort from any active state overrides the normal walk
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start && !abort) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_WAIT;
      ST_WAIT:  if (update_cycle_complete) w_state_nxt = ST_DWELL;
      ST_DWELL: if (r_dwell_cnt == '0) w_state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (!w_at_last || w_loop_again) w_state_nxt = ST_LOAD;
        else                            w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (abort && r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Datapath: step pointer, dwell counter, registered outputs and the sticky write error
  always_ff @(posedge clock) begin
    if (reset) begin
      r_step_index     <= '0;
      r_last_step      <= '0;
      r_dwell_cnt      <= '0;
      r_driver_enable  <= '0;
      r_timer_enable   <= 1'b0;
      r_cfg_busy_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) r_step_index <= '0;
        end
        ST_LOAD: begin
          r_driver_enable <= w_rd_mask;
          r_timer_enable  <= 1'b1;
        end
        ST_WAIT: begin
          if (update_cycle_complete) begin
            r_timer_enable <= 1'b0;
            r_dwell_cnt    <= w_rd_dwell;
          end
        end
        ST_DWELL: begin
          if (r_dwell_cnt != '0) r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
        end
        ST_NEXT: begin
          if (!w_at_last)        r_step_index <= r_step_index + 4'd1;
          else if (w_loop_again) r_step_index <= '0;
        end
        ST_DONE: begin
          r_driver_enable <= '0;
        end
        default: ;
      endcase
      if (abort && r_state != ST_IDLE) begin
        r_timer_enable  <= 1'b0;
        r_driver_enable <= '0;
      end
      if (w_ctrl_we) begin
        r_last_step <= w_last_step_wr;
      end
      if (w_cfg_wr && r_state != ST_IDLE) begin
        r_cfg_busy_error <= 1'b1;
      end
    end
  end

  assign timer_enable   = r_timer_enable;
  assign driver_enable  = r_driver_enable;
  assign busy           = (r_state != ST_IDLE);
  assign step_index     = r_step_index;
  assign done           = (r_state == ST_DONE);
  assign cfg_busy_error = r_cfg_busy_error;

endmodule
